vc_queue_domain_gate: RTL and testbench
=======================================

VC_QUEUE_DOMAIN_GATE -- requirements
Module: vc_queue_domain_gate

Interface
REQ-001: Parameters SHALL be, one per line:
  p_msg_nbits  8  message width in bits
  p_num_msgs  2  depth of the downstream vc_Queue
  p_max_burst  8  maximum consecutive same-domain grants while the other domain waits
  c_addr_nbits  $clog2(p_num_msgs)  local constant, not set from outside
REQ-002: Ports SHALL be, one per line:
  clk  in  1  clock
  reset  in  1  asynchronous, active-high reset
  in0_val  in  1  input 0 message valid
  in0_rdy  out  1  input 0 ready
  in0_domain  in  1  input 0 security domain
  in0_msg  in  p_msg_nbits  input 0 payload
  in1_val / in1_rdy / in1_domain / in1_msg  as in0, for input 1
  out_val  out  1  valid toward the downstream queue enq_val
  out_rdy  in  1  downstream queue enq_rdy
  out_domain  out  1  domain of out_msg, driven to the queue domain port
  out_msg  out  p_msg_nbits  payload toward queue enq_msg
  q_num_free_entries  in  c_addr_nbits+1  downstream queue free-entry count
  cur_domain  out  1  domain currently admitted
  draining  out  1  high while in state DRAIN
REQ-003: The block SHALL have one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-004: The FSM SHALL have two states: OPEN (admit traffic of cur_domain) and DRAIN (admit nothing; wait for the queue to empty).
REQ-005: An input SHALL be "match" when inX_val=1 and inX_domain=cur_domain, and "mismatch" when inX_val=1 and inX_domain!=cur_domain.
REQ-006: In OPEN, the grant SHALL go to the single match input; when both inputs match, it SHALL go to the input named by the round-robin pointer rr.
REQ-007: out_val SHALL equal the granted input's val; out_msg SHALL be the granted input's msg, combinationally, with zero latency.
REQ-008: out_domain SHALL equal cur_domain at all times.
REQ-009: inX_rdy SHALL be out_rdy AND (state=OPEN) AND (X granted); a non-granted input SHALL see rdy=0.
REQ-010: A transfer SHALL occur when out_val and out_rdy are both 1.
REQ-011: On a transfer from inX, rr SHALL point to the other input on the next cycle; otherwise rr SHALL hold.
REQ-012: burst_cnt (width $clog2(p_max_burst+1)) SHALL increment on each transfer made while some input is mismatch, and SHALL clear on a transfer with no mismatch input; it SHALL saturate at p_max_burst.
REQ-013: OPEN SHALL go to DRAIN when a mismatch input exists AND either no match input exists or burst_cnt=p_max_burst.
REQ-014: The cycle that takes the OPEN->DRAIN transition SHALL grant nothing.
REQ-015: In DRAIN, out_val=0, in0_rdy=0, in1_rdy=0 and draining=1.
REQ-016: In DRAIN, when q_num_free_entries=p_num_msgs, the next cycle SHALL invert cur_domain, clear burst_cnt and enter OPEN.
REQ-017: The DRAIN->OPEN switch SHALL complete even if the mismatch input has dropped val meanwhile.
REQ-018: With no valid input, the block SHALL stay in OPEN, cur_domain SHALL hold, and out_val=0.
REQ-019: Messages of the two domains SHALL never be resident in the downstream queue at the same time.

Reset
REQ-020: While reset=1, state SHALL be OPEN, cur_domain=0, rr=in0, burst_cnt=0, draining=0, out_val=0, in0_rdy=0, in1_rdy=0.
REQ-021: Reset SHALL take effect immediately, including mid-DRAIN; the first cycle after release SHALL behave as OPEN with domain 0.

Verification
REQ-022: After reset: in0 val=1, domain=0, msg=0x11; out_rdy=1 -> same cycle out_val=1, out_msg=0x11, out_domain=0, in0_rdy=1.
REQ-023: Both inputs domain 0 and continuously valid, out_rdy=1 -> grants alternate in0, in1, in0, in1; rr starts at in0.
REQ-024: Domain-1 message on in1 with the queue holding 1 of 2 entries -> DRAIN; no grants until q_num_free_entries=2; then cur_domain=1 and the in1 message is transferred in the following OPEN cycle.
REQ-025: in0 domain 0 continuously valid, in1 domain 1 waiting, p_max_burst=8 -> exactly 8 in0 transfers, then DRAIN, then in1 is served.
REQ-026: Reset asserted during DRAIN -> outputs immediately return to reset values; after release, cur_domain=0 and state=OPEN.
REQ-027: out_rdy=0 held for 5 cycles with in0 match valid -> no transfer, rr and burst_cnt unchanged, in0_msg stable at out_msg.

Source files
------------

// File: rtl/vc_queue_domain_gate.sv
// Two-input admission gate for a vc_Queue. At any time only one security domain may
// enter the queue, and the gate drains the queue before it switches domain.
module vc_queue_domain_gate #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_msgs  = 2,
    parameter int p_max_burst = 8,
    localparam int c_addr_nbits = $clog2(p_num_msgs)
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   in0_val,
    output logic                   in0_rdy,
    input  logic                   in0_domain,
    input  logic [p_msg_nbits-1:0] in0_msg,

    input  logic                   in1_val,
    output logic                   in1_rdy,
    input  logic                   in1_domain,
    input  logic [p_msg_nbits-1:0] in1_msg,

    output logic                   out_val,
    input  logic                   out_rdy,
    output logic                   out_domain,
    output logic [p_msg_nbits-1:0] out_msg,

    input  logic [c_addr_nbits:0]  q_num_free_entries,

    output logic                   cur_domain,
    output logic                   draining
);

    localparam int c_burst_nbits = $clog2(p_max_burst + 1);
    localparam logic [c_burst_nbits-1:0] c_burst_max   = c_burst_nbits'(p_max_burst);
    localparam logic [c_addr_nbits:0]    c_queue_empty = (c_addr_nbits + 1)'(p_num_msgs);

    typedef enum logic {
        ST_OPEN,
        ST_DRAIN
    } state_t;

    state_t                   state;
    logic                     rr;          // 0 = in0 next on a tie, 1 = in1
    logic [c_burst_nbits-1:0] burst_cnt;

    logic match0, match1, mismatch0, mismatch1;
    logic any_match, any_mismatch;
    logic go_drain, admit;
    logic grant0, grant1, transfer;

    assign match0    = in0_val && (in0_domain == cur_domain);
    assign match1    = in1_val && (in1_domain == cur_domain);
    assign mismatch0 = in0_val && (in0_domain != cur_domain);
    assign mismatch1 = in1_val && (in1_domain != cur_domain);

    assign any_match    = match0 | match1;
    assign any_mismatch = mismatch0 | mismatch1;

    // The other domain wins the gate when nothing of ours is waiting or our burst is spent.
    assign go_drain = (state == ST_OPEN) && any_mismatch &&
                      (!any_match || (burst_cnt == c_burst_max));

    // Reset also gates the grant so nothing leaks out while reset is held.
    assign admit  = !reset && (state == ST_OPEN) && !go_drain;
    assign grant0 = admit && match0 && (!match1 || !rr);
    assign grant1 = admit && match1 && (!match0 ||  rr);

    assign out_val    = grant0 | grant1;
    assign out_msg    = grant1 ? in1_msg : in0_msg;
    assign out_domain = cur_domain;
    assign in0_rdy    = out_rdy & grant0;
    assign in1_rdy    = out_rdy & grant1;
    assign transfer   = out_val & out_rdy;

    // NOTE: state is updated with non-blocking assignments only, so every branch
    // below reads the pre-edge values of state, rr and burst_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_OPEN;
            cur_domain <= 1'b0;
            rr         <= 1'b0;
            burst_cnt  <= '0;
            draining   <= 1'b0;
        end else begin
            case (state)
                ST_OPEN: begin
                    if (go_drain) begin
                        state    <= ST_DRAIN;
                        draining <= 1'b1;
                    end else if (transfer) begin
                        rr <= grant0;
                        if (!any_mismatch)
                            burst_cnt <= '0;
                        else if (burst_cnt != c_burst_max)
                            burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Switch only once every entry of the old domain has left the queue.
                    if (q_num_free_entries == c_queue_empty) begin
                        state      <= ST_OPEN;
                        cur_domain <= ~cur_domain;
                        burst_cnt  <= '0;
                        draining   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_OPEN;
                    draining <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_queue_domain_gate.sv
// Self-checking bench for vc_queue_domain_gate: cycle vectors with expected outputs,
// plus a scoreboard of expected transfers checked against out_msg/out_domain.
module tb_vc_queue_domain_gate;

    logic       clk;
    logic       reset;
    logic       in0_val, in0_rdy, in0_domain;
    logic [7:0] in0_msg;
    logic       in1_val, in1_rdy, in1_domain;
    logic [7:0] in1_msg;
    logic       out_val, out_rdy, out_domain;
    logic [7:0] out_msg;
    logic [1:0] q_num_free_entries;
    logic       cur_domain, draining;

    vc_queue_domain_gate #(
        .p_msg_nbits (8),
        .p_num_msgs  (2),
        .p_max_burst (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in0_val            (in0_val),
        .in0_rdy            (in0_rdy),
        .in0_domain         (in0_domain),
        .in0_msg            (in0_msg),
        .in1_val            (in1_val),
        .in1_rdy            (in1_rdy),
        .in1_domain         (in1_domain),
        .in1_msg            (in1_msg),
        .out_val            (out_val),
        .out_rdy            (out_rdy),
        .out_domain         (out_domain),
        .out_msg            (out_msg),
        .q_num_free_entries (q_num_free_entries),
        .cur_domain         (cur_domain),
        .draining           (draining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       v0;
        bit       d0;
        bit [7:0] m0;
        bit       v1;
        bit       d1;
        bit [7:0] m1;
        bit       ordy;
        bit [1:0] qf;
        bit       e_val;
        bit [7:0] e_msg;
        bit       e_r0;
        bit       e_r1;
        bit       e_dom;
        bit       e_drn;
    } vec_t;

    typedef struct {
        bit [7:0] msg;
        bit       dom;
    } xfer_t;

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit v0, input bit d0, input bit [7:0] m0,
                                input bit v1, input bit d1, input bit [7:0] m1,
                                input bit ordy, input bit [1:0] qf,
                                input bit e_val, input bit [7:0] e_msg, input bit e_r0,
                                input bit e_r1, input bit e_dom, input bit e_drn);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.m0 = m0; v.v1 = v1; v.d1 = d1; v.m1 = m1;
        v.ordy = ordy; v.qf = qf; v.e_val = e_val; v.e_msg = e_msg; v.e_r0 = e_r0;
        v.e_r1 = e_r1; v.e_dom = e_dom; v.e_drn = e_drn;
        return v;
    endfunction

    // One cycle: drive just after the edge, push any expected transfer, compare mid-cycle.
    task automatic apply(input vec_t v, input string name);
        xfer_t x;
        @(posedge clk);
        #1;
        reset              = v.rst;
        in0_val            = v.v0;
        in0_domain         = v.d0;
        in0_msg            = v.m0;
        in1_val            = v.v1;
        in1_domain         = v.d1;
        in1_msg            = v.m1;
        out_rdy            = v.ordy;
        q_num_free_entries = v.qf;
        if (!v.rst && v.e_val && v.ordy) begin
            x.msg = v.e_msg;
            x.dom = v.e_dom;
            sb_q.push_back(x);
        end
        @(negedge clk);
        check({name, ".out_val"},    32'(out_val),    32'(v.e_val));
        check({name, ".in0_rdy"},    32'(in0_rdy),    32'(v.e_r0));
        check({name, ".in1_rdy"},    32'(in1_rdy),    32'(v.e_r1));
        check({name, ".cur_domain"}, 32'(cur_domain), 32'(v.e_dom));
        check({name, ".out_domain"}, 32'(out_domain), 32'(v.e_dom));
        check({name, ".draining"},   32'(draining),   32'(v.e_drn));
        if (v.e_val)
            check({name, ".out_msg"}, 32'(out_msg), 32'(v.e_msg));
    endtask

    // Scoreboard: every observed transfer must match the oldest expected one.
    always @(negedge clk) begin
        xfer_t x;
        if (reset === 1'b0 && out_val === 1'b1 && out_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb.unexpected_xfer", 32'(out_msg), 32'hffff_ffff);
            end else begin
                x = sb_q.pop_front();
                check("sb.msg", 32'(out_msg),    32'(x.msg));
                check("sb.dom", 32'(out_domain), 32'(x.dom));
            end
        end
    end

    vec_t tbl[23];

    initial begin
        reset = 1'b1;
        in0_val = 1'b0; in0_domain = 1'b0; in0_msg = '0;
        in1_val = 1'b0; in1_domain = 1'b0; in1_msg = '0;
        out_rdy = 1'b0; q_num_free_entries = 2'd2;

        //            rst v0 d0 m0     v1 d1 m1     rdy qf  val msg    r0 r1 dom drn
        // Reset holds outputs low even with a valid input, then zero-latency pass-through.
        tbl[0]  = mk(1, 1, 0, 8'h11, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h11, 0, 0, 8'h00, 1, 2,  1, 8'h11, 1, 0, 0, 0);
        // Round robin from in0 after reset.
        tbl[2]  = mk(1, 1, 0, 8'h20, 1, 0, 8'h30, 1, 2,  0, 8'h00, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8'h20, 1, 0, 8'h30, 1, 2,  1, 8'h20, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 8'h21, 1, 0, 8'h31, 1, 2,  1, 8'h31, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 8'h22, 1, 0, 8'h32, 1, 2,  1, 8'h22, 1, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 8'h23, 1, 0, 8'h33, 1, 2,  1, 8'h33, 0, 1, 0, 0);
        // Back-pressure for 5 cycles: no transfer, rr stays on in0.
        for (int i = 7; i < 12; i++)
            tbl[i] = mk(0, 1, 0, 8'h44, 0, 0, 8'h00, 0, 2,  1, 8'h44, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 8'h45, 1, 0, 8'h55, 1, 2,  1, 8'h45, 1, 0, 0, 0);
        // Domain-1 request with one entry resident: drain, then switch and serve.
        tbl[13] = mk(0, 0, 0, 8'h00, 1, 1, 8'h66, 1, 1,  0, 8'h00, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 8'h00, 1, 1, 8'h66, 1, 1,  0, 8'h00, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 8'h00, 1, 1, 8'h66, 1, 1,  0, 8'h00, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 8'h00, 1, 1, 8'h66, 1, 2,  0, 8'h00, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 8'h00, 1, 1, 8'h66, 1, 2,  1, 8'h66, 0, 1, 1, 0);
        // Requester drops val mid-drain; the switch still completes, then idle holds.
        tbl[18] = mk(0, 1, 0, 8'h77, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1,  0, 8'h00, 0, 0, 1, 1);
        tbl[20] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 1, 1);
        tbl[21] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 23; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Burst limit: exactly 8 in0 transfers while in1 (domain 1) waits.
        for (int i = 0; i < 8; i++)
            apply(mk(0, 1, 0, 8'h80 + 8'(i), 1, 1, 8'h99, 1, 2,  1, 8'h80 + 8'(i), 1, 0, 0, 0),
                  $sformatf("burst%0d", i));
        apply(mk(0, 1, 0, 8'h88, 1, 1, 8'h99, 1, 2,  0, 8'h00, 0, 0, 0, 0), "burst_stop");
        apply(mk(0, 1, 0, 8'h88, 1, 1, 8'h99, 1, 1,  0, 8'h00, 0, 0, 0, 1), "burst_drain1");
        apply(mk(0, 1, 0, 8'h88, 1, 1, 8'h99, 1, 2,  0, 8'h00, 0, 0, 0, 1), "burst_drain2");
        apply(mk(0, 1, 0, 8'h88, 1, 1, 8'h99, 1, 2,  1, 8'h99, 0, 1, 1, 0), "burst_serve_in1");

        // Reset in the middle of a drain clears immediately; domain 0 is open afterwards.
        apply(mk(0, 1, 0, 8'h5a, 0, 0, 8'h00, 1, 2,  0, 8'h00, 0, 0, 1, 0), "rstdrn_stop");
        apply(mk(0, 1, 0, 8'h5a, 0, 0, 8'h00, 1, 1,  0, 8'h00, 0, 0, 1, 1), "rstdrn_drain");
        apply(mk(1, 1, 0, 8'h5a, 0, 0, 8'h00, 1, 1,  0, 8'h00, 0, 0, 0, 0), "rstdrn_reset");
        apply(mk(0, 1, 0, 8'h5a, 0, 0, 8'h00, 1, 1,  1, 8'h5a, 1, 0, 0, 0), "rstdrn_after");

        @(posedge clk);
        check("sb.pending", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
